// File: rtl/hermes_port_buffer.sv
// rtl/hermes_port_buffer.sv - credit-based Hermes flit FIFO with cut-through or store-and-forward release
module hermes_port_buffer #(
  parameter int HERMES_FLIT_SIZE  = 32,
  parameter int BUFFER_SIZE       = 8,
  parameter bit STORE_AND_FORWARD = 1'b0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rx_i,
  input  logic                          eop_i,
  output logic                          credit_o,
  input  logic [HERMES_FLIT_SIZE-1:0]   data_i,
  output logic                          tx_o,
  output logic                          eop_o,
  input  logic                          credit_i,
  output logic [HERMES_FLIT_SIZE-1:0]   data_o,
  output logic                          header_o,
  output logic [$clog2(BUFFER_SIZE):0]  occupancy_o,
  output logic [$clog2(BUFFER_SIZE):0]  pkt_count_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUFFER_SIZE);

  typedef enum logic { IN_HEADER, IN_PAYLOAD } in_state_e;
  typedef enum logic { OUT_HEADER, OUT_PAYLOAD } out_state_e;

  logic [HERMES_FLIT_SIZE:0] mem [BUFFER_SIZE];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          occupancy, pkt_count;
  in_state_e                 in_state;
  out_state_e                out_state;
  logic                      push, pop, release_ok;

  assign credit_o    = (occupancy != FULL);
  assign push        = rx_i && credit_o;
  assign pop         = tx_o && credit_i;
  assign data_o      = mem[rd_ptr][HERMES_FLIT_SIZE-1:0];
  assign eop_o       = mem[rd_ptr][HERMES_FLIT_SIZE];
  assign header_o    = (out_state == OUT_HEADER) && (occupancy != '0);
  assign occupancy_o = occupancy;
  assign pkt_count_o = pkt_count;

  // Full-buffer term keeps packets longer than the FIFO from deadlocking.
  assign release_ok = (pkt_count != '0) || (out_state == OUT_PAYLOAD) || (occupancy == FULL);
  assign tx_o       = (occupancy != '0) && (!STORE_AND_FORWARD || release_ok);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < BUFFER_SIZE; i++) mem[i] <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
      pkt_count <= '0;
      in_state  <= IN_HEADER;
      out_state <= OUT_HEADER;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {eop_i, data_i};
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);

      case ({push, pop})
        2'b10:   occupancy <= occupancy + CNT_W'(1);
        2'b01:   occupancy <= occupancy - CNT_W'(1);
        default: occupancy <= occupancy;
      endcase

      case ({push && eop_i, pop && eop_o})
        2'b10:   pkt_count <= pkt_count + CNT_W'(1);
        2'b01:   pkt_count <= pkt_count - CNT_W'(1);
        default: pkt_count <= pkt_count;
      endcase

      if (push) begin
        case (in_state)
          IN_HEADER:  in_state <= eop_i ? IN_HEADER : IN_PAYLOAD;
          IN_PAYLOAD: in_state <= eop_i ? IN_HEADER : IN_PAYLOAD;
          default:    in_state <= IN_HEADER;
        endcase
      end

      if (pop) begin
        case (out_state)
          OUT_HEADER:  out_state <= eop_o ? OUT_HEADER : OUT_PAYLOAD;
          OUT_PAYLOAD: out_state <= eop_o ? OUT_HEADER : OUT_PAYLOAD;
          default:     out_state <= OUT_HEADER;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hermes_port_buffer.sv
// tb/tb_hermes_port_buffer.sv - scoreboard bench for hermes_port_buffer in cut-through and store-and-forward builds
module tb_hermes_port_buffer;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        sel = 1'b0;
  logic        rx = 1'b0, eop_in = 1'b0, cin = 1'b0;
  logic [31:0] din = '0;

  logic        rx_a, cin_a, rx_b, cin_b;
  logic        credit_a, tx_a, eop_a, hdr_a, credit_b, tx_b, eop_b, hdr_b;
  logic [31:0] data_a, data_b;
  logic [3:0]  occ_a, pkt_a, occ_b, pkt_b;

  logic        m_credit, m_tx, m_eop, m_hdr;
  logic [31:0] m_data;
  logic [3:0]  m_occ, m_pkt;

  int n_cmp = 0;
  int n_mis = 0;
  logic [32:0] sb[$];
  logic        exp_hdr = 1'b1;

  always #5 clk = ~clk;

  assign rx_a  = sel ? 1'b0 : rx;
  assign cin_a = sel ? 1'b0 : cin;
  assign rx_b  = sel ? rx : 1'b0;
  assign cin_b = sel ? cin : 1'b0;

  assign m_credit = sel ? credit_b : credit_a;
  assign m_tx     = sel ? tx_b : tx_a;
  assign m_eop    = sel ? eop_b : eop_a;
  assign m_hdr    = sel ? hdr_b : hdr_a;
  assign m_data   = sel ? data_b : data_a;
  assign m_occ    = sel ? occ_b : occ_a;
  assign m_pkt    = sel ? pkt_b : pkt_a;

  hermes_port_buffer #(.HERMES_FLIT_SIZE(32), .BUFFER_SIZE(8), .STORE_AND_FORWARD(1'b0)) dut_ct (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx_a), .eop_i(eop_in), .credit_o(credit_a),
    .data_i(din), .tx_o(tx_a), .eop_o(eop_a), .credit_i(cin_a), .data_o(data_a),
    .header_o(hdr_a), .occupancy_o(occ_a), .pkt_count_o(pkt_a)
  );

  hermes_port_buffer #(.HERMES_FLIT_SIZE(32), .BUFFER_SIZE(8), .STORE_AND_FORWARD(1'b1)) dut_sf (
    .clk_i(clk), .rst_ni(rst_ni), .rx_i(rx_b), .eop_i(eop_in), .credit_o(credit_b),
    .data_i(din), .tx_o(tx_b), .eop_o(eop_b), .credit_i(cin_b), .data_o(data_b),
    .header_o(hdr_b), .occupancy_o(occ_b), .pkt_count_o(pkt_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are stable at the falling edge, so this sees exactly what the next rising edge will act on.
  always @(negedge clk) begin
    if (!rst_ni) begin
      sb.delete();
      exp_hdr = 1'b1;
    end else begin
      if (m_tx && cin) begin
        if (sb.size() == 0) begin
          check_eq("pop_from_empty_scoreboard", 64'd1, 64'd0);
        end else begin
          logic [32:0] e;
          e = sb.pop_front();
          check_eq("pop_data", 64'(m_data), 64'(e[31:0]));
          check_eq("pop_eop", 64'(m_eop), 64'(e[32]));
          check_eq("pop_header", 64'(m_hdr), 64'(exp_hdr));
          exp_hdr = e[32];
        end
      end
      if (rx && m_credit) sb.push_back({eop_in, din});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic e);
    logic acc;
    int   n;
    rx = 1'b1; din = d; eop_in = e;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 50) begin
      acc = m_credit;
      step();
      n++;
    end
    if (!acc) check_eq("send_timeout", 64'd0, 64'd1);
    rx = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && m_occ != 0; i++) step();
    check_eq("drain_occ", 64'(m_occ), 64'd0);
    check_eq("drain_pkt", 64'(m_pkt), 64'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_credit"}, 64'(m_credit), 64'd1);
    check_eq({tag, "_tx"}, 64'(m_tx), 64'd0);
    check_eq({tag, "_eop"}, 64'(m_eop), 64'd0);
    check_eq({tag, "_hdr"}, 64'(m_hdr), 64'd0);
    check_eq({tag, "_data"}, 64'(m_data), 64'd0);
    check_eq({tag, "_occ"}, 64'(m_occ), 64'd0);
    check_eq({tag, "_pkt"}, 64'(m_pkt), 64'd0);
  endtask

  initial begin
    #1;
    step();
    check_reset_outputs("reset");
    step();
    rst_ni = 1'b1;

    // Cut-through 3-flit packet
    cin = 1'b1;
    send(32'hA0, 1'b0);
    check_eq("ct_tx_after_first_push", 64'(m_tx), 64'd1);
    check_eq("ct_hdr_first", 64'(m_hdr), 64'd1);
    send(32'hA1, 1'b0);
    send(32'hA2, 1'b1);
    check_eq("ct_pkt_peak", 64'(m_pkt), 64'd1);
    step();
    check_eq("ct_pkt_after", 64'(m_pkt), 64'd0);
    check_eq("ct_occ_after", 64'(m_occ), 64'd0);

    // Fill the buffer without draining
    cin = 1'b0;
    for (int i = 0; i < 8; i++) send(32'hB0 + 32'(i), 1'b0);
    check_eq("full_credit", 64'(m_credit), 64'd0);
    check_eq("full_occ", 64'(m_occ), 64'd8);
    rx = 1'b1; din = 32'hBF; eop_in = 1'b0;
    step();
    rx = 1'b0;
    check_eq("full_ignored_occ", 64'(m_occ), 64'd8);
    check_eq("full_ignored_credit", 64'(m_credit), 64'd0);
    cin = 1'b1;
    step();
    cin = 1'b0;
    check_eq("full_credit_back", 64'(m_credit), 64'd1);
    check_eq("full_pop_occ", 64'(m_occ), 64'd7);
    step();
    check_eq("credit_held_high", 64'(m_credit), 64'd1);

    // Bring occupancy to 4, then push and pop together across the pointer wrap
    cin = 1'b1;
    for (int i = 0; i < 3; i++) step();
    check_eq("mid_occ", 64'(m_occ), 64'd4);
    for (int i = 0; i < 10; i++) begin
      rx = 1'b1; din = 32'hC0 + 32'(i); eop_in = (i == 9);
      step();
      check_eq("simul_occ", 64'(m_occ), 64'd4);
    end
    rx = 1'b0; eop_in = 1'b0;
    drain();

    // Single-flit packets
    cin = 1'b0;
    for (int i = 0; i < 3; i++) send(32'hD0 + 32'(i), 1'b1);
    check_eq("single_pkt", 64'(m_pkt), 64'd3);
    check_eq("single_occ", 64'(m_occ), 64'd3);
    check_eq("single_hdr", 64'(m_hdr), 64'd1);
    cin = 1'b1;
    drain();

    // Reset mid-packet
    cin = 1'b0;
    for (int i = 0; i < 5; i++) send(32'hE0 + 32'(i), 1'b0);
    check_eq("pre_reset_occ", 64'(m_occ), 64'd5);
    rst_ni = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    step();
    rst_ni = 1'b1;
    cin = 1'b1;
    send(32'hF0, 1'b0);
    check_eq("post_reset_hdr", 64'(m_hdr), 64'd1);
    check_eq("post_reset_data", 64'(m_data), 64'hF0);
    send(32'hF1, 1'b1);
    drain();

    // Store-and-forward build
    rst_ni = 1'b0;
    cin = 1'b0;
    step();
    sel = 1'b1;
    step();
    rst_ni = 1'b1;
    check_reset_outputs("sf_reset");
    cin = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send(32'h10 + 32'(i), 1'b0);
      check_eq("sf_hold_tx", 64'(m_tx), 64'd0);
    end
    send(32'h14, 1'b1);
    check_eq("sf_release_tx", 64'(m_tx), 64'd1);
    for (int i = 0; i < 5; i++) begin
      check_eq("sf_burst_tx", 64'(m_tx), 64'd1);
      step();
    end
    check_eq("sf_burst_occ", 64'(m_occ), 64'd0);

    // Packet longer than the buffer degrades to cut-through once full
    for (int i = 0; i < 12; i++) begin
      send(32'h20 + 32'(i), i == 11);
      if (i == 6) begin
        check_eq("sf_long_hold_tx", 64'(m_tx), 64'd0);
        check_eq("sf_long_occ7", 64'(m_occ), 64'd7);
      end
      if (i == 7) begin
        check_eq("sf_long_full_tx", 64'(m_tx), 64'd1);
        check_eq("sf_long_occ8", 64'(m_occ), 64'd8);
      end
    end
    drain();
    check_eq("sf_scoreboard_empty", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
